// File: rtl/alu_mul_seq_pkg.sv
// Shared definitions for the sequential multiplier: ALU control codes,
// controller states and the iteration count.
package alu_mul_seq_pkg;

    localparam logic [3:0] ALU_CTRL_AND = 4'b0000;
    localparam logic [3:0] ALU_CTRL_OR  = 4'b0001;
    localparam logic [3:0] ALU_CTRL_ADD = 4'b0010;
    localparam logic [3:0] ALU_CTRL_SUB = 4'b0110;
    localparam logic [3:0] ALU_CTRL_SLT = 4'b0111;

    localparam int unsigned MUL_ITERATIONS = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned 32x32->64 shift-and-add multiplier that borrows the shared ALU's
// adder for 32 cycles, holding the HI/LO product for the datapath.
module alu_mul_seq
    import alu_mul_seq_pkg::*;
#(
    parameter logic [3:0] ALU_ADD  = ALU_CTRL_ADD,
    parameter logic [3:0] ALU_IDLE = ALU_CTRL_AND
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] src1_i,
    input  logic [31:0] src2_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic [31:0] alu_src1_o,
    output logic [31:0] alu_src2_o,
    output logic [3:0]  alu_ctrl_o,
    input  logic [31:0] alu_result_i
);

    localparam logic [5:0] LAST_CNT = 6'(MUL_ITERATIONS - 1);

    mul_state_t  state, state_next;
    logic [31:0] mcand, mcand_next;
    logic [31:0] hi, hi_next;
    logic [31:0] lo, lo_next;
    logic [5:0]  cnt, cnt_next;
    logic        carry;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            mcand <= mcand_next;
            hi    <= hi_next;
            lo    <= lo_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        mcand_next = mcand;
        hi_next    = hi;
        lo_next    = lo;
        cnt_next   = cnt;
        carry      = 1'b0;
        alu_src1_o = '0;
        alu_src2_o = '0;
        alu_ctrl_o = ALU_IDLE;

        case (state)
            ST_RUN: begin
                alu_src1_o = hi;
                alu_src2_o = lo[0] ? mcand : '0;
                alu_ctrl_o = ALU_ADD;
                // The ALU drops the adder carry; a wrapped sum is smaller than hi.
                carry      = (alu_result_i < hi);
                hi_next    = {carry, alu_result_i[31:1]};
                lo_next    = {alu_result_i[0], lo[31:1]};
                cnt_next   = cnt + 6'd1;
                if (cnt == LAST_CNT) begin
                    state_next = ST_DONE;
                end
            end
            default: begin
                if (start_i) begin
                    state_next = ST_RUN;
                    mcand_next = src1_i;
                    lo_next    = src2_i;
                    hi_next    = '0;
                    cnt_next   = '0;
                end else begin
                    state_next = ST_IDLE;
                end
            end
        endcase
    end

    assign busy_o = (state == ST_RUN);
    assign done_o = (state == ST_DONE);
    assign hi_o   = hi;
    assign lo_o   = lo;

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle unsigned 32×32→64 multiplier controller that borrows the shared 32-bit ALU instead of owning an adder. It runs shift-and-add over 32 cycles, each cycle driving the ALU operand and control inputs and consuming its result. It holds the HI/LO product for the CPU datapath's multiply path. It sits beside the ALU; a mux in the datapath gives it ALU ownership while `busy_o` is high.

## Interface
- `ALU_ADD`, default 4'b0010: ALU control code issued during iterations.
- `ALU_IDLE`, default 4'b0000: ALU control code driven when not iterating (AND).
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_i` in 1: reset; one clock, synchronous, active-high.
- `start_i` in 1: start request, sampled on the clock edge.
- `src1_i` in 32: multiplicand, captured on accepted start.
- `src2_i` in 32: multiplier, captured on accepted start.
- `busy_o` out 1: iteration in progress; ALU owned by this block.
- `done_o` out 1: one-cycle pulse; product valid.
- `hi_o` out 32: product bits [63:32].
- `lo_o` out 32: product bits [31:0].
- `alu_src1_o` out 32: to ALU `src1_i`.
- `alu_src2_o` out 32: to ALU `src2_i`.
- `alu_ctrl_o` out 4: to ALU `ctrl_i`.
- `alu_result_i` in 32: from ALU `result_o`, combinational, same cycle.

## Operation
- Registers:
  - `mcand` (32).
  - `hi` (32).
  - `lo` (32). It starts as the multiplier.
  - `cnt` (6).
  - `state`.
- States:
  - IDLE: waiting for a start.
  - RUN: iterating.
  - DONE: product just completed.
- IDLE: `start_i`=1 → RUN. On that edge: `mcand`←`src1_i`, `lo`←`src2_i`, `hi`←0, `cnt`←0.
- RUN, each cycle:
  - Drive `alu_src1_o`=`hi`.
  - Drive `alu_src2_o`= `lo[0]` ? `mcand` : 0.
  - Drive `alu_ctrl_o`=`ALU_ADD`.
  - Compute carry = (`alu_result_i` < `hi`), unsigned.
  - On the edge: `hi`←{carry, `alu_result_i[31:1]`}, `lo`←{`alu_result_i[0]`, `lo[31:1]`}, `cnt`←`cnt`+1.
  - When `cnt`==31 on the edge → DONE.
- DONE: `done_o`=1 for this single cycle.
  - `start_i`=1 → RUN, with captures as in IDLE (back-to-back).
  - Otherwise → IDLE.
- Outside RUN: `alu_src1_o`=0, `alu_src2_o`=0, `alu_ctrl_o`=`ALU_IDLE`.
- `busy_o` = (state==RUN).
- `hi_o`/`lo_o` = `hi`/`lo` registers directly. They change during RUN. They are valid from the DONE cycle and held until the next accepted start.
- `start_i` during RUN: ignored, no restart.
- All arithmetic unsigned, 32-bit. The ALU's 32-bit add drops the carry, so the controller reconstructs it via the unsigned compare above.
- Reset (any state, including mid-RUN) → IDLE with:
  - `hi`=`lo`=`mcand`=0, `cnt`=0.
  - `busy_o`=0, `done_o`=0, `hi_o`=`lo_o`=0.
  - ALU outputs at idle values.
- A partial product is discarded on reset.

## Timing
- Start accepted at edge E0. `busy_o`=1 during cycles E0+1 … E0+32.
- At E0+32 the state moves to DONE. `done_o`=1 in cycle E0+33 only. Product readable from E0+33.
- Latency from start to done pulse: 33 cycles. Throughput: one product per 33 cycles, with start asserted in the DONE cycle.
- The ALU path is combinational through the external ALU within one cycle: `hi`/`lo[0]`/`mcand` → ALU → carry/shift → registers.
- The `ALU_ADD` control code must be stable the whole RUN cycle.
- Reset is sampled at the edge: `rst_i` high at edge N gives reset values from cycle N+1. Reset overrides `start_i`.

## Structure
- Shared package:
  - ALU control codes: AND 4'b0000, OR 4'b0001, ADD 4'b0010, SUB 4'b0110, SLT 4'b0111.
  - State encoding for IDLE/RUN/DONE.
  - Iteration count constant 32.
- No internal sub-module: FSM, counter and shift registers live in one module.
- Test wrapper `mul_unit` instantiates `alu_mul_seq` plus the existing `ALU`, wired port-to-port. The bench drives `mul_unit`.

## Test plan
- 3 × 5: start with `src1_i`=3, `src2_i`=5 → `done_o` pulse 33 cycles after start, `hi_o`=0, `lo_o`=15. `busy_o` high exactly 32 cycles. `alu_ctrl_o`=4'b0010 throughout RUN.
- Carry case: 0xFFFFFFFF × 0xFFFFFFFF → `hi_o`=0xFFFFFFFE, `lo_o`=0x00000001.
- Zero operands: 0 × 0x12345678 → `hi_o`=`lo_o`=0. `alu_src2_o`=0 every RUN cycle.
- Start while busy: 7 × 9 started, `start_i` pulsed with 2 × 2 at cycle 10 of RUN → ignored, result `lo_o`=63. Then start in the DONE cycle with 0x10000 × 0x10000 → no IDLE cycle, second done 33 cycles later, `hi_o`=1, `lo_o`=0.
- Reset mid-op: `rst_i` high at cycle 15 of RUN → next cycle `busy_o`=0, `hi_o`=`lo_o`=0, `alu_ctrl_o`=4'b0000. No `done_o` pulse follows.
- Random: 1000 random operand pairs, each checked against a 64-bit reference product.
